mem_arbiter: RTL

//  Shares the single-port word memory between the core's instruction-fetch port and its

---
 rtl/mem_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Shares one single-port word memory between the fetch port and the load/store port.
// Data accesses win, bounded by a streak limit; bad addresses fault instead of accessing memory.
module mem_arbiter #(
    parameter logic [31:0] ENTRY    = 32'h8000_0000,
    parameter int          DEPTH    = 2048,
    parameter int          MAX_DRUN = 4,
    localparam int         IDX_W    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_req,
    input  logic [31:0]      if_addr,
    output logic             if_gnt,
    output logic             if_rvalid,
    output logic [31:0]      if_rdata,
    output logic             if_fault,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [3:0]       d_be,
    input  logic [31:0]      d_addr,
    input  logic [31:0]      d_wdata,
    output logic             d_gnt,
    output logic             d_rvalid,
    output logic [31:0]      d_rdata,
    output logic             d_fault,
    output logic             mem_en,
    output logic             mem_we,
    output logic [3:0]       mem_be,
    output logic [IDX_W-1:0] mem_idx,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_D
    } owner_t;

    localparam logic [3:0] RUN_MAX = 4'(MAX_DRUN);

    owner_t      owner_q, owner_d;
    logic        fault_q, fault_d;
    logic        read_q, read_d;
    logic [3:0]  run_cnt;
    logic [31:0] sel_addr;
    logic [31:0] off;
    logic        addr_fault;
    logic [31:0] resp_data;

    // Addresses below ENTRY wrap to a huge offset and so fail the range test too.
    always_comb begin
        d_gnt      = 1'b0;
        if_gnt     = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_be     = 4'b0000;
        mem_idx    = '0;
        mem_wdata  = 32'h0;
        if (!reset) begin
            if (d_req && !(if_req && run_cnt == RUN_MAX))
                d_gnt = 1'b1;
            else if (if_req)
                if_gnt = 1'b1;
        end
        sel_addr   = d_gnt ? d_addr : if_addr;
        off        = sel_addr - ENTRY;
        addr_fault = (off[1:0] != 2'b00) || ({2'b00, off[31:2]} >= 32'(DEPTH));
        if ((d_gnt || if_gnt) && !addr_fault) begin
            mem_en  = 1'b1;
            mem_idx = off[IDX_W+1:2];
            if (d_gnt) begin
                mem_we    = d_we && (d_be != 4'b0000);
                mem_be    = d_we ? d_be : 4'b0000;
                mem_wdata = d_wdata;
            end
        end
        owner_d = d_gnt ? OWN_D : (if_gnt ? OWN_IF : OWN_NONE);
        fault_d = (d_gnt || if_gnt) && addr_fault;
        read_d  = if_gnt || (d_gnt && !d_we);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= OWN_NONE;
            fault_q <= 1'b0;
            read_q  <= 1'b0;
            run_cnt <= 4'd0;
        end else begin
            owner_q <= owner_d;
            fault_q <= fault_d;
            read_q  <= read_d;
            if (!if_req || if_gnt)
                run_cnt <= 4'd0;
            else if (d_gnt && run_cnt != RUN_MAX)
                run_cnt <= run_cnt + 4'd1;
        end
    end

    // Gating with reset drops a response that is in flight when reset rises.
    always_comb begin
        resp_data = (read_q && !fault_q) ? mem_rdata : 32'h0;
        if_rvalid = !reset && (owner_q == OWN_IF);
        d_rvalid  = !reset && (owner_q == OWN_D);
        if_rdata  = if_rvalid ? resp_data : 32'h0;
        d_rdata   = d_rvalid ? resp_data : 32'h0;
        if_fault  = if_rvalid && fault_q;
        d_fault   = d_rvalid && fault_q;
    end

endmodule
